lb_initiator: RTL and testbench
===============================

# lb_initiator

Local-bus initiator that issues register write/read commands onto the localbus and collects the responses returned by the regmap responder. It sits between a host command source (UART/Ethernet command decoder) and the localbus `wvalid/wctrl/waddr/wdata` → `rready/rctrl/raddr/rdata` path. It pipelines up to `MAXOUT` commands, matches in-order responses against a queue of expected ctrl/addr, and reports each result to the host with an error flag.

## Interface
- `LBCWIDTH`, 8, ctrl field width
- `LBAWIDTH`, 24, address width
- `LBDWIDTH`, 32, data width
- `WRITECMD`, 1, ctrl code for write
- `READCMD`, 0, ctrl code for read
- `MAXOUT`, 4, max outstanding commands (power of 2, 2..16)
- `TIMEOUT`, 64, cycles without a response before head is retired as error

Ports:
- `clk` in 1: localbus clock
- `rst_n` in 1: synchronous reset, active low
- `req_valid` in 1: host command valid
- `req_ready` out 1: command accepted when `req_valid & req_ready` at posedge
- `req_ctrl` in LBCWIDTH, `req_addr` in LBAWIDTH, `req_data` in LBDWIDTH: host command
- `lb_wvalid` out 1, `lb_wctrl` out LBCWIDTH, `lb_waddr` out LBAWIDTH, `lb_wdata` out LBDWIDTH: bus command
- `lb_rready` in 1, `lb_rctrl` in LBCWIDTH, `lb_raddr` in LBAWIDTH, `lb_rdata` in LBDWIDTH: bus response
- `rsp_valid` out 1: one-cycle result strobe (host cannot stall)
- `rsp_ctrl` out LBCWIDTH, `rsp_addr` out LBAWIDTH, `rsp_data` out LBDWIDTH: result
- `rsp_err` out 1: result is mismatch or timeout
- `outstanding` out $clog2(MAXOUT)+1: commands in flight
- `stray_cnt` out 16: responses received with nothing outstanding (saturating)

## Operation
- Accept: `req_ready = rst_n_q & (outstanding < MAXOUT)`; on accept, register command onto `lb_w*`, pulse `lb_wvalid` one cycle, push {ctrl, addr} into expected FIFO (depth MAXOUT).
- `lb_wctrl/waddr/wdata` hold last value when `lb_wvalid`=0.
- Response: on `lb_rready`=1 with FIFO non-empty, pop head; `rsp_ctrl/addr/data` ← `lb_r*`; `rsp_err` = (`lb_rctrl`≠head.ctrl) | (`lb_raddr`≠head.addr). Write responses echo wdata; reads carry register value (0xdeadbeef for unmapped, not an error here).
- `lb_rready` with FIFO empty: no `rsp_valid`, `stray_cnt`+1 (saturate at 0xFFFF).
- `outstanding` = FIFO occupancy; simultaneous push and pop leaves it unchanged; back-to-back accept every cycle until full.
- FSM: IDLE (outstanding=0, timer cleared) → BUSY on push; BUSY → IDLE when last entry popped with no push same cycle.
- Timeout (when enabled): timer counts in BUSY, clears on every pop; on reaching TIMEOUT−1 pop head, emit `rsp_valid`=1, `rsp_err`=1, `rsp_ctrl/addr`=head, `rsp_data`=0xdeadbeef. A `lb_rready` in the same cycle wins; timer clears.
- Reset mid-operation: FIFO flushed, all outputs to reset value; responses arriving after reset count as stray.

## Timing
- Reset values: `req_ready`=0 during reset and first cycle after, `lb_wvalid`=0, `lb_w*`=0, `rsp_valid`=0, `rsp_*`=0, `rsp_err`=0, `outstanding`=0, `stray_cnt`=0.
- Accept at edge N → `lb_wvalid`=1 during cycle N+1.
- `lb_rready` sampled at edge M → `rsp_valid` during cycle M+1.
- With regmap responder (3-cycle rready latency): accept-to-`rsp_valid` = 5 cycles.
- FIFO push visible to `req_ready` next cycle; full stalls acceptance exactly at MAXOUT.

## Configuration
- `LB_INITIATOR_TIMEOUT_EN`: defined → timeout timer and timeout retirement as above. Undefined → no timer; BUSY waits indefinitely; `rsp_err` reflects only ctrl/addr mismatch.

## Test plan
- Single write ctrl=1 addr=0x000010 data=0x12345678 → `lb_wvalid` 1 cycle later, `rsp_valid` with data 0x12345678, err=0, outstanding back to 0.
- 6 back-to-back reads, MAXOUT=4, responder latency 3 → `req_ready` drops after 4th, all 6 results in order, err=0, no lost or duplicate strobes.
- Responder returns raddr=0x000020 for request addr 0x000024 → `rsp_err`=1, `rsp_addr`=0x000020.
- Unsolicited `lb_rready` while IDLE → no `rsp_valid`, `stray_cnt`=1.
- Timeout enabled, TIMEOUT=64, responder silent → `rsp_valid` 64 cycles after first BUSY cycle, err=1, data=0xdeadbeef; late response → stray_cnt+1.
- `rst_n`=0 with 3 outstanding → outstanding=0, `rsp_valid`=0; 3 subsequent responses → stray_cnt=3.

Source files
------------

// File: rtl/lb_initiator.sv
// Localbus initiator: issues host commands on lb_w*, matches in-order responses on lb_r*.
// Define LB_INITIATOR_TIMEOUT_EN to retire a silent head entry as an error after TIMEOUT cycles.
module lb_initiator #(
  parameter int unsigned LBCWIDTH = 8,
  parameter int unsigned LBAWIDTH = 24,
  parameter int unsigned LBDWIDTH = 32,
  parameter int unsigned WRITECMD = 1,
  parameter int unsigned READCMD  = 0,
  parameter int unsigned MAXOUT   = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [LBCWIDTH-1:0]       req_ctrl,
  input  logic [LBAWIDTH-1:0]       req_addr,
  input  logic [LBDWIDTH-1:0]       req_data,
  output logic                      lb_wvalid,
  output logic [LBCWIDTH-1:0]       lb_wctrl,
  output logic [LBAWIDTH-1:0]       lb_waddr,
  output logic [LBDWIDTH-1:0]       lb_wdata,
  input  logic                      lb_rready,
  input  logic [LBCWIDTH-1:0]       lb_rctrl,
  input  logic [LBAWIDTH-1:0]       lb_raddr,
  input  logic [LBDWIDTH-1:0]       lb_rdata,
  output logic                      rsp_valid,
  output logic [LBCWIDTH-1:0]       rsp_ctrl,
  output logic [LBAWIDTH-1:0]       rsp_addr,
  output logic [LBDWIDTH-1:0]       rsp_data,
  output logic                      rsp_err,
  output logic [$clog2(MAXOUT):0]   outstanding,
  output logic [15:0]               stray_cnt
);

  localparam int unsigned PtrW = $clog2(MAXOUT);
  localparam int unsigned CntW = $clog2(MAXOUT) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAXOUT);
  localparam logic [LBDWIDTH-1:0] DeadData = LBDWIDTH'(32'hdeadbeef);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e state_q, state_d;
  logic   busy;

  logic                rst_n_q;
  logic [LBCWIDTH-1:0] exp_ctrl_q [MAXOUT];
  logic [LBAWIDTH-1:0] exp_addr_q [MAXOUT];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;

  logic                push, pop, rsp_pop, tmo_pop, stray;
  logic [LBCWIDTH-1:0] head_ctrl;
  logic [LBAWIDTH-1:0] head_addr;
  logic                mismatch;

  logic                lb_wvalid_q;
  logic [LBCWIDTH-1:0] lb_wctrl_q;
  logic [LBAWIDTH-1:0] lb_waddr_q;
  logic [LBDWIDTH-1:0] lb_wdata_q;
  logic                rsp_valid_q;
  logic [LBCWIDTH-1:0] rsp_ctrl_q;
  logic [LBAWIDTH-1:0] rsp_addr_q;
  logic [LBDWIDTH-1:0] rsp_data_q;
  logic                rsp_err_q;
  logic [15:0]         stray_cnt_q;

  // rst_n_q keeps acceptance off for the cycle in which reset is released.
  assign req_ready = rst_n_q & (count_q < MaxCnt);
  assign push      = req_valid & req_ready;
  assign rsp_pop   = lb_rready & (count_q != '0);
  assign stray     = lb_rready & (count_q == '0);
  assign pop       = rsp_pop | tmo_pop;

  assign head_ctrl = exp_ctrl_q[rd_ptr_q];
  assign head_addr = exp_addr_q[rd_ptr_q];
  assign mismatch  = (lb_rctrl != head_ctrl) | (lb_raddr != head_addr);

`ifdef LB_INITIATOR_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT) + 1;
  logic [TmrW-1:0] timer_q;

  // A real response arriving on the expiry cycle takes precedence over the timeout.
  assign tmo_pop = busy & (timer_q == TmrW'(TIMEOUT - 1)) & ~rsp_pop;

  always_ff @(posedge clk) begin
    if (!rst_n || !busy || pop) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign tmo_pop = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (push) state_d = StBusy;
      StBusy: if (pop && !push && count_q == CntW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StBusy:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Expected-response storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      exp_ctrl_q[wr_ptr_q] <= req_ctrl;
      exp_addr_q[wr_ptr_q] <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rst_n_q <= 1'b1;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lb_wvalid_q <= 1'b0;
      lb_wctrl_q  <= '0;
      lb_waddr_q  <= '0;
      lb_wdata_q  <= '0;
    end else begin
      lb_wvalid_q <= push;
      if (push) begin
        lb_wctrl_q <= req_ctrl;
        lb_waddr_q <= req_addr;
        lb_wdata_q <= req_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_ctrl_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      stray_cnt_q <= '0;
    end else begin
      rsp_valid_q <= pop;
      if (rsp_pop) begin
        rsp_ctrl_q <= lb_rctrl;
        rsp_addr_q <= lb_raddr;
        rsp_data_q <= lb_rdata;
        rsp_err_q  <= mismatch;
      end else if (tmo_pop) begin
        rsp_ctrl_q <= head_ctrl;
        rsp_addr_q <= head_addr;
        rsp_data_q <= DeadData;
        rsp_err_q  <= 1'b1;
      end
      if (stray && stray_cnt_q != '1) stray_cnt_q <= stray_cnt_q + 1'b1;
    end
  end

  assign lb_wvalid   = lb_wvalid_q;
  assign lb_wctrl    = lb_wctrl_q;
  assign lb_waddr    = lb_waddr_q;
  assign lb_wdata    = lb_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_ctrl    = rsp_ctrl_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign outstanding = count_q;
  assign stray_cnt   = stray_cnt_q;

  cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n) count_q <= MaxCnt);
  idle_empty: assert property (@(posedge clk) disable iff (!rst_n) !busy |-> count_q == '0);
  no_push_full: assert property (@(posedge clk) disable iff (!rst_n) count_q == MaxCnt |-> !push);
  cmd_codes_differ: assert property (@(posedge clk) WRITECMD != READCMD);
  params_legal: assert property (@(posedge clk)
    MAXOUT >= 2 && MAXOUT <= 16 && (MAXOUT & (MAXOUT - 1)) == 0 && TIMEOUT >= 2);

endmodule

// File: tb/tb_lb_initiator.sv
// Directed bench for lb_initiator: vector table plus hand-written multi-cycle sequences.
module tb_lb_initiator;
  localparam int unsigned CW = 8;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [CW-1:0] req_ctrl;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          lb_wvalid;
  logic [CW-1:0] lb_wctrl;
  logic [AW-1:0] lb_waddr;
  logic [DW-1:0] lb_wdata;
  logic          lb_rready;
  logic [CW-1:0] lb_rctrl;
  logic [AW-1:0] lb_raddr;
  logic [DW-1:0] lb_rdata;
  logic          rsp_valid, rsp_err;
  logic [CW-1:0] rsp_ctrl;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic [2:0]    outstanding;
  logic [15:0]   stray_cnt;

  always #5 clk = ~clk;

  lb_initiator #(
    .LBCWIDTH(CW), .LBAWIDTH(AW), .LBDWIDTH(DW), .WRITECMD(1), .READCMD(0),
    .MAXOUT(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_data(req_data),
    .lb_wvalid(lb_wvalid), .lb_wctrl(lb_wctrl), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
    .lb_rready(lb_rready), .lb_rctrl(lb_rctrl), .lb_raddr(lb_raddr), .lb_rdata(lb_rdata),
    .rsp_valid(rsp_valid), .rsp_ctrl(rsp_ctrl), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .outstanding(outstanding), .stray_cnt(stray_cnt)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          err;
  } rsp_t;

  typedef struct {
    logic [CW-1:0] c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  rsp_t rsp_q[$];
  bit   auto_resp = 1'b0;
  logic          pv[3];
  logic [CW-1:0] pc[3];
  logic [AW-1:0] pa[3];
  logic [DW-1:0] pd[3];

  function automatic logic [DW-1:0] reg_val(input logic [AW-1:0] a);
    return 32'hc0de0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: sample outputs 1 time unit after the edge, then run the 3-cycle responder.
  task automatic tick();
    rsp_t r;
    @(posedge clk);
    #1;
    if (rsp_valid) begin
      r.c = rsp_ctrl; r.a = rsp_addr; r.d = rsp_data; r.err = rsp_err;
      rsp_q.push_back(r);
    end
    if (auto_resp) begin
      lb_rready = pv[2]; lb_rctrl = pc[2]; lb_raddr = pa[2]; lb_rdata = pd[2];
      for (int i = 2; i > 0; i--) begin
        pv[i] = pv[i-1]; pc[i] = pc[i-1]; pa[i] = pa[i-1]; pd[i] = pd[i-1];
      end
      pv[0] = lb_wvalid; pc[0] = lb_wctrl; pa[0] = lb_waddr;
      pd[0] = (lb_wctrl == 8'd1) ? lb_wdata : reg_val(lb_waddr);
    end
  endtask

  task automatic resp_off();
    auto_resp = 1'b0;
    lb_rready = 1'b0;
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_ctrl = c; req_addr = a; req_data = d;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    tick();
    req_valid = 1'b0;
  endtask

  task automatic bus_rsp(input logic [CW-1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    lb_rready = 1'b1; lb_rctrl = c; lb_raddr = a; lb_rdata = d;
    tick();
    lb_rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   n;
    int   idx;
    int   max_out;
    bit   acc;
    bit   any_rsp;

    vecs[0] = '{8'd1, 24'h000010, 32'h12345678, 32'h12345678};
    vecs[1] = '{8'd0, 24'h000024, 32'h00000000, 32'hc0de0024};
    vecs[2] = '{8'd1, 24'habcdef, 32'hffff0000, 32'hffff0000};
    vecs[3] = '{8'd0, 24'h00ffff, 32'h00000001, 32'hc0deffff};

    rst_n = 1'b0; req_valid = 1'b0; req_ctrl = '0; req_addr = '0; req_data = '0;
    lb_rready = 1'b0; lb_rctrl = '0; lb_raddr = '0; lb_rdata = '0;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pc[i] = '0; pa[i] = '0; pd[i] = '0; end

    repeat (3) tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wvalid", lb_wvalid, 0);
    chk("rst_waddr", lb_waddr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_stray", stray_cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single transactions through the 3-cycle responder
    auto_resp = 1'b1;
    foreach (vecs[v]) begin
      rsp_q.delete();
      send(vecs[v].c, vecs[v].a, vecs[v].d);
      chk($sformatf("v%0d_wvalid", v), lb_wvalid, 1);
      chk($sformatf("v%0d_wctrl", v), lb_wctrl, vecs[v].c);
      chk($sformatf("v%0d_waddr", v), lb_waddr, vecs[v].a);
      chk($sformatf("v%0d_wdata", v), lb_wdata, vecs[v].d);
      chk($sformatf("v%0d_outst1", v), outstanding, 1);
      tick();
      chk($sformatf("v%0d_wvalid_pulse", v), lb_wvalid, 0);
      chk($sformatf("v%0d_waddr_hold", v), lb_waddr, vecs[v].a);
      n = 1;
      while (rsp_q.size() == 0 && n < 30) begin tick(); n++; end
      chk($sformatf("v%0d_latency", v), n, 4);
      if (rsp_q.size() > 0) begin
        chk($sformatf("v%0d_rsp_ctrl", v), rsp_q[0].c, vecs[v].c);
        chk($sformatf("v%0d_rsp_addr", v), rsp_q[0].a, vecs[v].a);
        chk($sformatf("v%0d_rsp_data", v), rsp_q[0].d, vecs[v].exp_d);
        chk($sformatf("v%0d_rsp_err", v), rsp_q[0].err, 0);
      end
      chk($sformatf("v%0d_outst0", v), outstanding, 0);
      repeat (3) tick();
    end

    // Six back-to-back reads against MAXOUT=4
    rsp_q.delete();
    idx = 0; n = 0; max_out = 0;
    req_valid = 1'b1; req_ctrl = 8'd0;
    while (idx < 6 && n < 60) begin
      req_addr = 24'h000100 + 24'(4 * idx);
      acc = req_ready;
      tick(); n++;
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (acc) begin
        idx++;
        if (idx == 4) begin
          chk("b2b_cycles_to_full", n, 4);
          chk("b2b_full_ready", req_ready, 0);
          chk("b2b_full_outst", outstanding, 4);
        end
      end
    end
    req_valid = 1'b0;
    repeat (20) tick();
    chk("b2b_accepted", idx, 6);
    chk("b2b_max_outst", max_out, 4);
    chk("b2b_rsp_count", rsp_q.size(), 6);
    for (int i = 0; i < 6 && i < rsp_q.size(); i++) begin
      chk($sformatf("b2b%0d_addr", i), rsp_q[i].a, 24'h000100 + 24'(4 * i));
      chk($sformatf("b2b%0d_data", i), rsp_q[i].d, reg_val(24'h000100 + 24'(4 * i)));
      chk($sformatf("b2b%0d_err", i), rsp_q[i].err, 0);
    end
    chk("b2b_outst0", outstanding, 0);

    // Address and ctrl mismatches
    resp_off();
    send(8'd0, 24'h000024, 32'h0);
    repeat (2) tick();
    bus_rsp(8'd0, 24'h000020, 32'hc0de0020);
    chk("mm_addr_valid", rsp_valid, 1);
    chk("mm_addr_err", rsp_err, 1);
    chk("mm_addr_addr", rsp_addr, 24'h000020);
    chk("mm_addr_outst", outstanding, 0);
    tick();
    chk("mm_valid_pulse", rsp_valid, 0);
    send(8'd1, 24'h000030, 32'h55);
    bus_rsp(8'd0, 24'h000030, 32'h55);
    chk("mm_ctrl_err", rsp_err, 1);
    chk("mm_ctrl_ctrl", rsp_ctrl, 0);

    // Unsolicited response while idle
    tick();
    bus_rsp(8'd0, 24'h000044, 32'h1);
    chk("stray_no_valid", rsp_valid, 0);
    chk("stray_cnt1", stray_cnt, 1);

`ifdef LB_INITIATOR_TIMEOUT_EN
    send(8'd0, 24'h000040, 32'h0);
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("tmo_latency", n, 64);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_data", rsp_data, 32'hdeadbeef);
    chk("tmo_addr", rsp_addr, 24'h000040);
    chk("tmo_ctrl", rsp_ctrl, 0);
    chk("tmo_outst", outstanding, 0);
    tick();
    bus_rsp(8'd0, 24'h000040, 32'hc0de0040);
    chk("tmo_late_no_valid", rsp_valid, 0);
    chk("tmo_late_stray", stray_cnt, 2);
`else
    send(8'd0, 24'h000040, 32'h0);
    any_rsp = 1'b0;
    for (int i = 0; i < 100; i++) begin tick(); if (rsp_valid) any_rsp = 1'b1; end
    chk("notmo_no_rsp", any_rsp, 0);
    chk("notmo_outst", outstanding, 1);
    bus_rsp(8'd0, 24'h000040, 32'hc0de0040);
    chk("notmo_rsp_valid", rsp_valid, 1);
    chk("notmo_rsp_err", rsp_err, 0);
    chk("notmo_rsp_data", rsp_data, 32'hc0de0040);
    tick();
    bus_rsp(8'd0, 24'h000040, 32'hc0de0040);
    chk("notmo_late_stray", stray_cnt, 2);
`endif

    // Reset with three commands in flight
    send(8'd0, 24'h000050, 32'h0);
    send(8'd0, 24'h000054, 32'h0);
    send(8'd0, 24'h000058, 32'h0);
    chk("mid_outst3", outstanding, 3);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_outst", outstanding, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_wvalid", lb_wvalid, 0);
    chk("mid_rst_waddr", lb_waddr, 0);
    chk("mid_rst_rsp_addr", rsp_addr, 0);
    chk("mid_rst_stray", stray_cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    rsp_q.delete();
    bus_rsp(8'd0, 24'h000050, 32'hc0de0050);
    bus_rsp(8'd0, 24'h000054, 32'hc0de0054);
    bus_rsp(8'd0, 24'h000058, 32'hc0de0058);
    tick();
    chk("mid_after_no_rsp", rsp_q.size(), 0);
    chk("mid_after_stray", stray_cnt, 3);
    chk("mid_after_outst", outstanding, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
